cu_multicycle: RTL and testbench

Multicycle control unit for the RV32I core. It replaces the single-cycle decoder with a state machine that sequences fetch, decode, execute, memory and write-back over several clocks, and stalls on ready/request handshakes to instruction and data memory. It has a wait-state timeout, sticky trap handling and a retired-instruction counter. It drives the existing datapath (PC, register file, ALU operand muxes, write-back mux, branch comparator) from one clock domain.

---
 rtl/cu_pkg.sv | 50 +++++
 rtl/cu_decoder.sv | 82 ++++++++
 rtl/cu_multicycle.sv | 182 ++++++++++++++++++
 tb/tb_cu_multicycle.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
// FSM states, instruction classes, opcodes, write-back and trap encodings.
package cu_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    CL_R      = 4'd0,
    CL_I      = 4'd1,
    CL_LOAD   = 4'd2,
    CL_STORE  = 4'd3,
    CL_BRANCH = 4'd4,
    CL_JAL    = 4'd5,
    CL_JALR   = 4'd6,
    CL_LUI    = 4'd7,
    CL_AUIPC  = 4'd8
  } class_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] WB_DM  = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [1:0] TRAP_NONE    = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
  localparam logic [1:0] TRAP_IMEM    = 2'b10;
  localparam logic [1:0] TRAP_DMEM    = 2'b11;

  function automatic logic is_mem(class_t c);
    return (c == CL_LOAD) || (c == CL_STORE);
  endfunction

endpackage

// File: rtl/cu_decoder.sv
// Combinational instruction decoder: IR to class, operand selects, register
// fields, func3/subsra and an illegal-opcode flag.
module cu_decoder
  import cu_pkg::*;
(
  input  logic [31:0] ir,
  output logic [3:0]  cls,
  output logic        illegal,
  output logic        opa_sel,
  output logic        opb_sel,
  output logic        subsra,
  output logic [2:0]  func3,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [1:0]  wb_sel
);

  always_comb begin
    cls     = CL_R;
    illegal = 1'b0;
    opa_sel = 1'b1;
    opb_sel = 1'b0;
    subsra  = 1'b0;
    func3   = ir[14:12];
    rs1     = ir[19:15];
    rs2     = ir[24:20];
    rd      = ir[11:7];
    wb_sel  = WB_ALU;
    case (ir[6:0])
      OP_R: subsra = ir[30];
      OP_IMM: begin
        cls     = CL_I;
        opb_sel = 1'b1;
        // Only SRAI carries the arithmetic-shift bit; other immediates use ir[30] as data.
        subsra  = (ir[14:12] == 3'b101) && ir[30];
      end
      OP_LOAD: begin
        cls     = CL_LOAD;
        opb_sel = 1'b1;
        wb_sel  = WB_DM;
      end
      OP_STORE: begin
        cls     = CL_STORE;
        opb_sel = 1'b1;
      end
      OP_BRANCH: begin
        cls     = CL_BRANCH;
        opa_sel = 1'b0;
        opb_sel = 1'b1;
      end
      OP_JAL: begin
        cls     = CL_JAL;
        opa_sel = 1'b0;
        opb_sel = 1'b1;
        func3   = 3'b000;
        wb_sel  = WB_PC4;
      end
      OP_JALR: begin
        cls     = CL_JALR;
        opb_sel = 1'b1;
        func3   = 3'b000;
        wb_sel  = WB_PC4;
      end
      OP_LUI: begin
        cls     = CL_LUI;
        opa_sel = 1'b0;
        opb_sel = 1'b1;
        func3   = 3'b000;
        rs1     = 5'd0;
      end
      OP_AUIPC: begin
        cls     = CL_AUIPC;
        opa_sel = 1'b0;
        opb_sel = 1'b1;
        func3   = 3'b000;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cu_multicycle.sv
// Multicycle RV32I control unit: sequences fetch/decode/execute/memory/write-back,
// stalls on memory handshakes with a wait-state timeout, sticky traps, retire counter.
module cu_multicycle
  import cu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int CNT_W    = 32,
  parameter int WAIT_MAX = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      IMinstruction,
  output logic             imem_req,
  input  logic             imem_ready,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ready,
  input  logic             branch_taken,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             ir_we,
  output logic             rf_we,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic [2:0]       func3,
  output logic             subsra,
  output logic             opa_sel,
  output logic             opb_sel,
  output logic [1:0]       wb_sel,
  output logic             halted,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instr_count,
  output logic [2:0]       fsm_state
);

  if (XLEN != 32) begin : g_xlen_check
    $error("cu_multicycle supports XLEN=32 only");
  end

  state_t      state;
  class_t      cls;
  logic [31:0] ir;
  logic [31:0] stall_cnt;
  logic        stall_expired;

  logic [3:0]  d_cls;
  logic        d_illegal, d_opa, d_opb, d_subsra;
  logic [2:0]  d_func3;
  logic [4:0]  d_rs1, d_rs2, d_rd;
  logic [1:0]  d_wb_sel;

  cu_decoder u_decoder (
    .ir      (ir),
    .cls     (d_cls),
    .illegal (d_illegal),
    .opa_sel (d_opa),
    .opb_sel (d_opb),
    .subsra  (d_subsra),
    .func3   (d_func3),
    .rs1     (d_rs1),
    .rs2     (d_rs2),
    .rd      (d_rd),
    .wb_sel  (d_wb_sel)
  );

  // The stall on which ready is still low becomes the WAIT_MAX-th; a ready in that same cycle wins.
  assign stall_expired = (WAIT_MAX != 0) && (stall_cnt == 32'(WAIT_MAX - 1));

  // Handshakes: a request stays high until its ready is seen high in the same
  // cycle, which completes the transfer; ready with no request pending is ignored.
  always_comb begin
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = 1'b0;
    rf_we    = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ready;
      end
      S_EXEC: begin
        if (cls == CL_BRANCH) begin
          pc_we  = 1'b1;
          pc_sel = branch_taken;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls == CL_STORE);
        pc_we    = (cls == CL_STORE) && dmem_ready;
      end
      S_WB: begin
        rf_we  = (rd != 5'd0);
        pc_we  = 1'b1;
        pc_sel = (cls == CL_JAL) || (cls == CL_JALR);
      end
      default: ;
    endcase
  end

  assign halted    = (state == S_TRAP);
  assign fsm_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cls         <= CL_R;
      ir          <= 32'd0;
      stall_cnt   <= 32'd0;
      instr_count <= '0;
      trap_cause  <= TRAP_NONE;
      rs1         <= 5'd0;
      rs2         <= 5'd0;
      rd          <= 5'd0;
      func3       <= 3'd0;
      subsra      <= 1'b0;
      opa_sel     <= 1'b0;
      opb_sel     <= 1'b0;
      wb_sel      <= 2'b00;
    end else begin
      if (pc_we) instr_count <= instr_count + CNT_W'(1);
      case (state)
        S_IDLE: state <= S_FETCH;
        S_FETCH: begin
          if (imem_ready) begin
            ir        <= IMinstruction;
            stall_cnt <= 32'd0;
            state     <= S_DECODE;
          end else if (stall_expired) begin
            stall_cnt  <= 32'd0;
            trap_cause <= TRAP_IMEM;
            state      <= S_TRAP;
          end else begin
            stall_cnt <= stall_cnt + 32'd1;
          end
        end
        S_DECODE: begin
          if (d_illegal) begin
            trap_cause <= TRAP_ILLEGAL;
            state      <= S_TRAP;
          end else begin
            cls     <= class_t'(d_cls);
            rs1     <= d_rs1;
            rs2     <= d_rs2;
            rd      <= d_rd;
            func3   <= d_func3;
            subsra  <= d_subsra;
            opa_sel <= d_opa;
            opb_sel <= d_opb;
            wb_sel  <= d_wb_sel;
            state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (cls == CL_BRANCH) state <= S_FETCH;
          else if (is_mem(cls)) state <= S_MEM;
          else                  state <= S_WB;
        end
        S_MEM: begin
          if (dmem_ready) begin
            stall_cnt <= 32'd0;
            state     <= (cls == CL_LOAD) ? S_WB : S_FETCH;
          end else if (stall_expired) begin
            stall_cnt  <= 32'd0;
            trap_cause <= TRAP_DMEM;
            state      <= S_TRAP;
          end else begin
            stall_cnt <= stall_cnt + 32'd1;
          end
        end
        S_WB:    state <= S_FETCH;
        S_TRAP:  state <= S_TRAP;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cu_multicycle.sv
// Bench for cu_multicycle: directed cases plus random instructions with random
// wait states, checked against a per-instruction timing/control reference model.
module tb_cu_multicycle;
  import cu_pkg::*;

  localparam int CNT_W    = 32;
  localparam int WAIT_MAX = 4;

  localparam logic [31:0] I_ADD = 32'h002081B3;  // add x3,x1,x2
  localparam logic [31:0] I_LW  = 32'h0040A283;  // lw  x5,4(x1)
  localparam logic [31:0] I_BEQ = 32'h00208463;  // beq x1,x2,8
  localparam logic [31:0] I_SW  = 32'h0020A223;  // sw  x2,4(x1)

  logic             clk, reset;
  logic [31:0]      IMinstruction;
  logic             imem_req, imem_ready;
  logic             dmem_req, dmem_we, dmem_ready;
  logic             branch_taken;
  logic             pc_we, pc_sel, ir_we, rf_we;
  logic [4:0]       rs1, rs2, rd;
  logic [2:0]       func3;
  logic             subsra, opa_sel, opb_sel;
  logic [1:0]       wb_sel;
  logic             halted;
  logic [1:0]       trap_cause;
  logic [CNT_W-1:0] instr_count;
  logic [2:0]       fsm_state;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_count;
  logic [31:0] exp_q[$];
  logic [6:0]  ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                           7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

  typedef struct packed {
    int         cyc;
    int         dreq;
    logic       rfw;
    logic [1:0] wb;
    logic       pcsel;
    logic       store;
    logic       opa;
    logic       opb;
    logic       sub;
    logic [2:0] f3;
    logic [4:0] rs1;
  } exp_t;

  cu_multicycle #(.XLEN(32), .CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .reset(reset), .IMinstruction(IMinstruction),
    .imem_req(imem_req), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .branch_taken(branch_taken), .pc_we(pc_we), .pc_sel(pc_sel), .ir_we(ir_we),
    .rf_we(rf_we), .rs1(rs1), .rs2(rs2), .rd(rd), .func3(func3), .subsra(subsra),
    .opa_sel(opa_sel), .opb_sel(opb_sel), .wb_sel(wb_sel), .halted(halted),
    .trap_cause(trap_cause), .instr_count(instr_count), .fsm_state(fsm_state)
  );

  // Clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [63:0] ctrl_vec();
    return 64'({imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_sel, rf_we, rs1, rs2, rd,
                func3, subsra, opa_sel, opb_sel, wb_sel, halted, trap_cause});
  endfunction

  // Reference: what one instruction must do, derived from its class table.
  function automatic exp_t model(input logic [31:0] i, input int iw, input int dw, input logic taken);
    exp_t e;
    e.cyc = 4; e.dreq = 0; e.rfw = 1'b1; e.wb = 2'b01; e.pcsel = 1'b0; e.store = 1'b0;
    e.opa = 1'b1; e.opb = 1'b1; e.sub = 1'b0; e.f3 = i[14:12]; e.rs1 = i[19:15];
    case (i[6:0])
      7'b0110011: begin e.opb = 1'b0; e.sub = i[30]; end
      7'b0010011: e.sub = (i[14:12] == 3'b101) ? i[30] : 1'b0;
      7'b0000011: begin e.cyc = 5 + dw; e.dreq = dw + 1; e.wb = 2'b00; end
      7'b0100011: begin e.cyc = 4 + dw; e.dreq = dw + 1; e.rfw = 1'b0; e.store = 1'b1; end
      7'b1100011: begin e.cyc = 3; e.rfw = 1'b0; e.pcsel = taken; e.opa = 1'b0; end
      7'b1101111: begin e.opa = 1'b0; e.f3 = 3'b000; e.wb = 2'b10; e.pcsel = 1'b1; end
      7'b1100111: begin e.f3 = 3'b000; e.wb = 2'b10; e.pcsel = 1'b1; end
      7'b0110111: begin e.opa = 1'b0; e.f3 = 3'b000; e.rs1 = 5'd0; end
      default:    begin e.opa = 1'b0; e.f3 = 3'b000; end
    endcase
    e.cyc = e.cyc + iw;
    if (i[11:7] == 5'd0) e.rfw = 1'b0;
    return e;
  endfunction

  // Driver: acts as both memories for one instruction, starting in FETCH.
  task automatic run_instr(input logic [31:0] instr, input int iw, input int dw,
                           input logic taken, input string tag);
    exp_t        e;
    int          cyc = 0, iwait = 0, dwait = 0, pcw_n = 0, rfw_n = 0, dreq_n = 0, dwe_bad = 0;
    logic        done = 1'b0;
    logic [4:0]  s_rs1 = 5'd0, s_rd = 5'd0;
    logic [2:0]  s_f3 = 3'd0;
    logic        s_opa = 1'b0, s_opb = 1'b0, s_sub = 1'b0, s_pcsel = 1'b0;
    logic [1:0]  s_wb = 2'b00;
    logic [31:0] lat;
    e = model(instr, iw, dw, taken);
    exp_q.push_back(32'(e.cyc));
    while (!done && cyc < 40) begin
      branch_taken = taken;
      if (imem_req) begin
        if (iwait == iw) begin
          imem_ready = 1'b1;
          IMinstruction = instr;
        end else begin
          imem_ready = 1'b0;
          IMinstruction = $urandom();
          iwait++;
        end
      end else begin
        imem_ready = 1'($urandom_range(0, 1));
        IMinstruction = $urandom();
      end
      if (dmem_req) begin
        dreq_n++;
        if (dmem_we !== e.store) dwe_bad++;
        if (dwait == dw) dmem_ready = 1'b1;
        else begin
          dmem_ready = 1'b0;
          dwait++;
        end
      end else begin
        dmem_ready = 1'($urandom_range(0, 1));
      end
      #1;
      cyc++;
      if (rf_we) begin
        rfw_n++;
        s_rd = rd;
        s_wb = wb_sel;
      end
      if (pc_we) begin
        pcw_n++;
        done = 1'b1;
        s_pcsel = pc_sel; s_rs1 = rs1; s_f3 = func3;
        s_opa = opa_sel; s_opb = opb_sel; s_sub = subsra;
      end
      tick();
    end
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    exp_count = exp_count + 32'd1;
    lat = exp_q.pop_front();
    check({tag, "_retired"}, 64'(done), 64'd1);
    check({tag, "_latency"}, 64'(cyc), 64'(lat));
    check({tag, "_pc_we_cycles"}, 64'(pcw_n), 64'd1);
    check({tag, "_rf_we_cycles"}, 64'(rfw_n), 64'(e.rfw));
    if (e.rfw) begin
      check({tag, "_wb_sel"}, 64'(s_wb), 64'(e.wb));
      check({tag, "_rd"}, 64'(s_rd), 64'(instr[11:7]));
    end
    check({tag, "_pc_sel"}, 64'(s_pcsel), 64'(e.pcsel));
    check({tag, "_rs1"}, 64'(s_rs1), 64'(e.rs1));
    check({tag, "_func3"}, 64'(s_f3), 64'(e.f3));
    check({tag, "_opa"}, 64'(s_opa), 64'(e.opa));
    check({tag, "_opb"}, 64'(s_opb), 64'(e.opb));
    check({tag, "_subsra"}, 64'(s_sub), 64'(e.sub));
    check({tag, "_dmem_req_cycles"}, 64'(dreq_n), 64'(e.dreq));
    check({tag, "_dmem_we_bad"}, 64'(dwe_bad), 64'd0);
    check({tag, "_instr_count"}, 64'(instr_count), 64'(exp_count));
  endtask

  task automatic reset_dut(input string tag);
    reset = 1'b1;
    imem_ready = 1'b0; dmem_ready = 1'b0; branch_taken = 1'b0; IMinstruction = 32'd0;
    tick();
    check({tag, "_rst_ctrl"}, ctrl_vec(), 64'd0);
    check({tag, "_rst_state"}, 64'(fsm_state), 64'(S_IDLE));
    check({tag, "_rst_count"}, 64'(instr_count), 64'd0);
    reset = 1'b0;
    tick();
    check({tag, "_idle_to_fetch"}, 64'(fsm_state), 64'(S_FETCH));
    exp_count = 32'd0;
  endtask

  task automatic fetch_now(input logic [31:0] instr);
    imem_ready = 1'b1;
    IMinstruction = instr;
    tick();
    imem_ready = 1'b0;
    IMinstruction = $urandom();
  endtask

  initial begin
    reset = 1'b1;
    imem_ready = 1'b0; dmem_ready = 1'b0; branch_taken = 1'b0; IMinstruction = 32'd0;
    exp_count = 32'd0;

    reset_dut("init");
    run_instr(I_ADD, 0, 0, 1'b0, "add");
    run_instr(I_LW, 0, 3, 1'b0, "lw_wait3");
    run_instr(I_BEQ, 0, 0, 1'b1, "beq_taken");
    run_instr(I_SW, 0, 0, 1'b0, "sw");
    run_instr(I_ADD, 3, 0, 1'b0, "add_imem_ready_last");

    for (int n = 0; n < 40; n++) begin
      logic [31:0] r;
      r = $urandom();
      run_instr({r[31:7], ops[$urandom_range(0, 8)]}, $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
    end

    // Reset while a store is in MEM
    reset_dut("mr");
    run_instr(I_ADD, 0, 0, 1'b0, "mr_add");
    fetch_now(I_SW);
    tick();
    tick();
    check("mr_in_mem_req", 64'({dmem_req, dmem_we}), 64'd3);
    dmem_ready = 1'b0;
    reset = 1'b1;
    #1;
    check("mr_abort_ctrl", ctrl_vec(), 64'd0);
    check("mr_abort_state", 64'(fsm_state), 64'(S_IDLE));
    check("mr_abort_count", 64'(instr_count), 64'd0);
    reset = 1'b0;
    tick();
    check("mr_refetch", 64'({fsm_state, dmem_we, pc_we, rf_we}), 64'({S_FETCH, 3'b000}));
    exp_count = 32'd0;
    run_instr(I_ADD, 0, 0, 1'b0, "mr_resume");

    // Instruction-memory timeout
    reset_dut("it");
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("it_still_fetch%0d", k), 64'(fsm_state), 64'(S_FETCH));
    end
    tick();
    check("it_trap", 64'({fsm_state, halted, trap_cause}), 64'({S_TRAP, 1'b1, 2'b10}));
    check("it_no_req", 64'(imem_req), 64'd0);

    // Data-memory timeout
    reset_dut("dt");
    fetch_now(I_LW);
    tick();
    tick();
    check("dt_mem_req", 64'(dmem_req), 64'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("dt_still_mem%0d", k), 64'(fsm_state), 64'(S_MEM));
    end
    tick();
    check("dt_trap", 64'({fsm_state, halted, trap_cause}), 64'({S_TRAP, 1'b1, 2'b11}));

    // Illegal all-zero instruction, sticky trap
    reset_dut("il");
    fetch_now(32'd0);
    check("il_decode", 64'(fsm_state), 64'(S_DECODE));
    tick();
    check("il_trap", 64'({fsm_state, halted, trap_cause}), 64'({S_TRAP, 1'b1, 2'b01}));
    for (int k = 0; k < 12; k++) begin
      imem_ready = 1'($urandom_range(0, 1));
      dmem_ready = 1'($urandom_range(0, 1));
      tick();
      check($sformatf("il_hold%0d", k),
            64'({fsm_state, halted, trap_cause, imem_req, ir_we, dmem_req, dmem_we, pc_we, rf_we}),
            64'({S_TRAP, 1'b1, 2'b01, 6'b000000}));
    end
    check("il_count", 64'(instr_count), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
